// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph shared definitions
// bus addresses, status bits, fsm encodings
package uart_tx_periph_pkg;

  localparam logic [9:0] TX_ADDR   = 10'h54;
  localparam logic [9:0] STAT_ADDR = 10'h58;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic logic [7:0] stat_word(
    input logic ovf,
    input logic full,
    input logic busy
  );
    logic [7:0] w;
    w          = 8'h00;
    w[ST_OVF]  = ovf;
    w[ST_FULL] = full;
    w[ST_BUSY] = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// uart_tx_fifo: byte queue feeding the serialiser
// head is visible on dout whenever not empty
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 transmitter
// fifo-buffered, status readable at STAT_ADDR
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] address,
  input  logic [7:0] data,
  input  logic       write,
  output logic       tx,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow;
  logic          baud_end;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  assign baud_end = (baud == BAUD_MAX);
  assign push     = write && (address == TX_ADDR) && !full;
  assign pop      = !empty &&
                    ((state == S_IDLE) ||
                     (state == S_STOP && baud_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // frame sequencer: start, 8 data bits lsb first, stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud <= '0;
          if (!empty) begin
            shift <= head;
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (!empty) begin
              shift <= head;
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          baud  <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // sticky overflow: set on dropped push, cleared by status write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (write && address == TX_ADDR && full) begin
      overflow <= 1'b1;
    end else if (write && address == STAT_ADDR) begin
      overflow <= 1'b0;
    end
  end

  // registered busy and status read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      busy     <= (state != S_IDLE) || (count != '0);
      data_out <= (address == STAT_ADDR) ?
                  stat_word(overflow, full, busy) : 8'h00;
    end
  end

endmodule
